divergence_ctrl: RTL

- Sequences the per-SM predicate mask stack (`PStack`) for structured branch divergence.
- Consumes decoded IF/ELSE/ENDIF/OTHER instructions from the scheduler and drives the stack's push/pop/comp/d_in controls.
- Gates issue of OTHER instructions with the active lane mask.
- When no lane is active for a branch body, it consumes instructions up to the matching ELSE/ENDIF without issuing them, tracking nesting.

---
 rtl/divergence_ctrl.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/divergence_ctrl.sv
// divergence_ctrl
// ---------------
// This block sequences the per-SM predicate mask stack (PStack) for structured
// branch divergence. It takes decoded IF, ELSE, ENDIF and OTHER instructions from
// the scheduler and turns them into PStack push, pop and complement strobes.
//
// An OTHER instruction is issued to the lanes under the current top-of-stack mask.
//
// When a branch body has no active lane, the controller still consumes every
// instruction up to the matching ELSE or ENDIF, but it issues none of them. While
// it does this, a counter tracks how deeply IFs are nested inside the skipped body.
//
// Ports:
//   clk, reset                   clock; synchronous active-low reset
//   instr_valid / instr_ready    instruction handshake (transfer when both high)
//   instr_op                     00 OTHER, 01 IF, 10 ELSE, 11 ENDIF
//   pred                         per-lane branch condition for IF
//   ps_push/ps_pop/ps_comp       single-cycle PStack strobes (mutually exclusive)
//   ps_d_in                      mask pushed on IF
//   ps_tos                       PStack top of stack (registered in PStack)
//   ps_all_true/ps_all_false     PStack flags for the TOS
//   exec_valid / exec_mask       OTHER instruction issued, with lane enables
//   skipping                     controller is discarding an inactive body
//   depth                        current IF nesting depth (mirrors PStack pointer)
//   err_overflow/err_underflow   sticky error flags, cleared only by reset
module divergence_ctrl #(
    parameter int N_CORES     = 4,
    parameter int STACK_DEPTH = 3,
    parameter int NEST_W      = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   instr_valid,
    output logic                   instr_ready,
    input  logic [1:0]             instr_op,
    input  logic [N_CORES-1:0]     pred,
    output logic                   ps_push,
    output logic                   ps_pop,
    output logic                   ps_comp,
    output logic [N_CORES-1:0]     ps_d_in,
    input  logic [N_CORES-1:0]     ps_tos,
    input  logic                   ps_all_true,
    input  logic                   ps_all_false,
    output logic                   exec_valid,
    output logic [N_CORES-1:0]     exec_mask,
    output logic                   skipping,
    output logic [STACK_DEPTH-1:0] depth,
    output logic                   err_overflow,
    output logic                   err_underflow
);

    typedef enum logic [1:0] {
        OP_OTHER = 2'b00,
        OP_IF    = 2'b01,
        OP_ELSE  = 2'b10,
        OP_ENDIF = 2'b11
    } op_e;

    typedef enum logic [1:0] {
        IDLE = 2'b00,
        EVAL = 2'b01,
        SKIP = 2'b10
    } state_e;

    localparam logic [STACK_DEPTH-1:0] DEPTH_MAX = '1;
    localparam logic [NEST_W-1:0]      NEST_MAX  = '1;

    state_e                   state, state_d;
    logic [STACK_DEPTH-1:0]   depth_q, depth_d;
    logic [NEST_W-1:0]        nest, nest_d;
    logic                     err_ov_q, err_un_q;
    logic                     ov_set, un_set;
    op_e                      op;

    // EVAL branches only on all_false. The all_true flag is part of the PStack
    // interface, but this controller has no decision that depends on it.
    logic unused_all_true;
    assign unused_all_true = ps_all_true;

    assign op = op_e'(instr_op);

    // NOTE: every output and next-state variable gets a default before the case
    // statement, so that no path through the combinational block infers a latch.
    always_comb begin
        state_d     = state;
        depth_d     = depth_q;
        nest_d      = nest;
        ov_set      = 1'b0;
        un_set      = 1'b0;
        instr_ready = 1'b0;
        ps_push     = 1'b0;
        ps_pop      = 1'b0;
        ps_comp     = 1'b0;
        ps_d_in     = '0;
        exec_valid  = 1'b0;
        exec_mask   = '0;

        // During a reset cycle every strobe stays low, whatever the stale state is.
        if (reset) begin
            unique case (state)
                IDLE: begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        unique case (op)
                            OP_OTHER: begin
                                exec_valid = 1'b1;
                                exec_mask  = ps_tos;
                            end
                            OP_IF: begin
                                if (depth_q != DEPTH_MAX) begin
                                    ps_push = 1'b1;
                                    // A nested IF can only narrow the set of lanes
                                    // that the enclosing branches already enable.
                                    ps_d_in = pred & ps_tos;
                                    depth_d = depth_q + STACK_DEPTH'(1);
                                    state_d = EVAL;
                                end else begin
                                    ov_set = 1'b1;
                                end
                            end
                            OP_ELSE: begin
                                if (depth_q != '0) begin
                                    ps_comp = 1'b1;
                                    state_d = EVAL;
                                end else begin
                                    un_set = 1'b1;
                                end
                            end
                            OP_ENDIF: begin
                                if (depth_q != '0) begin
                                    ps_pop  = 1'b1;
                                    depth_d = depth_q - STACK_DEPTH'(1);
                                end else begin
                                    un_set = 1'b1;
                                end
                            end
                        endcase
                    end
                end

                // The PStack flags describe the new TOS only once the PStack has
                // registered the push or complement. This one-cycle stall lets the
                // controller read them after that update.
                EVAL: begin
                    if (ps_all_false) begin
                        state_d = SKIP;
                        nest_d  = '0;
                    end else begin
                        state_d = IDLE;
                    end
                end

                SKIP: begin
                    instr_ready = 1'b1;
                    if (instr_valid) begin
                        unique case (op)
                            OP_IF: begin
                                if (nest != NEST_MAX) begin
                                    nest_d = nest + NEST_W'(1);
                                end else begin
                                    ov_set = 1'b1;
                                end
                            end
                            OP_ELSE: begin
                                // An ELSE inside a nested, skipped IF belongs to
                                // that IF. Only the ELSE that matches the outer
                                // IF (nest == 0) can re-enable lanes.
                                if (nest == '0) begin
                                    ps_comp = 1'b1;
                                    state_d = EVAL;
                                end
                            end
                            OP_ENDIF: begin
                                if (nest != '0) begin
                                    nest_d = nest - NEST_W'(1);
                                end else if (depth_q != '0) begin
                                    ps_pop  = 1'b1;
                                    depth_d = depth_q - STACK_DEPTH'(1);
                                    state_d = IDLE;
                                end else begin
                                    state_d = IDLE;
                                end
                            end
                            default: ;  // OTHER: consumed without issue
                        endcase
                    end
                end

                default: state_d = IDLE;
            endcase
        end
    end

    // NOTE: state registers use non-blocking assignments, so every flop samples
    // pre-edge values no matter how the simulator orders the processes.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state    <= IDLE;
            depth_q  <= '0;
            nest     <= '0;
            err_ov_q <= 1'b0;
            err_un_q <= 1'b0;
        end else begin
            state    <= state_d;
            depth_q  <= depth_d;
            nest     <= nest_d;
            err_ov_q <= err_ov_q | ov_set;
            err_un_q <= err_un_q | un_set;
        end
    end

    assign skipping      = reset && (state == SKIP);
    assign depth         = depth_q;
    assign err_overflow  = err_ov_q;
    assign err_underflow = err_un_q;

endmodule
